// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: a valid/ready FIFO feeds a start/data/stop serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit between bit 7 and stop (8E1).
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH        = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 tx_data,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  output logic                       tx,
  output logic                       tx_busy,
  output logic [$clog2(DEPTH+1)-1:0] tx_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  state_t        r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_tx;
`ifdef UART_TX_PARITY_EN
  logic          r_parity;
`endif

  logic w_push;
  logic w_pop;
  logic w_bit_end;
  logic w_fifo_nempty;

  assign tx_ready      = (r_count != CW'(DEPTH));
  assign w_push        = tx_valid && tx_ready;
  assign w_fifo_nempty = (r_count != CW'(0));
  assign w_bit_end     = (r_baud == BW'(CLKS_PER_BIT - 1));
  // The FSM takes the FIFO head either from idle or on the last stop-bit cycle.
  assign w_pop         = w_fifo_nempty &&
                         ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

  assign tx       = r_tx;
  assign tx_count = r_count;
  assign tx_busy  = (r_state != S_IDLE) || w_fifo_nempty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= CW'(0);
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_baud    <= BW'(0);
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx      <= 1'b1;
          r_baud    <= BW'(0);
          r_bit_idx <= 3'd0;
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
`ifdef UART_TX_PARITY_EN
            r_parity <= even_parity(r_mem[r_rd_ptr]);
`endif
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_baud    <= BW'(0);
            r_bit_idx <= 3'd0;
            r_tx      <= r_shift[0];
            r_state   <= S_DATA;
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud <= BW'(0);
            if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_tx    <= r_parity;
              r_state <= S_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_baud  <= BW'(0);
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
`endif
        S_STOP: begin
          if (w_bit_end) begin
            r_baud <= BW'(0);
            // Chain straight into the next start bit when more data is queued.
            if (w_pop) begin
              r_shift <= r_mem[r_rd_ptr];
`ifdef UART_TX_PARITY_EN
              r_parity <= even_parity(r_mem[r_rd_ptr]);
`endif
              r_tx    <= 1'b0;
              r_state <= S_START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_baud  <= BW'(0);
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected bytes, a serial monitor decodes
// frames from tx and compares them in order. Honours UART_TX_PARITY_EN for 8E1 frames.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic          clk      = 1'b0;
  logic          reset    = 1'b0;
  logic [7:0]    tx_data  = 8'h00;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic          tx;
  logic          tx_busy;
  logic [CW-1:0] tx_count;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc   = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];

  uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_count (tx_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic mon_wait(input int n, output bit alive);
    alive = 1'b1;
    repeat (n) begin
      @(negedge clk);
      if (!reset) alive = 1'b0;
    end
  endtask

  // Serial monitor: decodes each frame at mid-bit and compares against the scoreboard head.
  initial begin : monitor
    logic [7:0] d;
    logic [7:0] e;
    bit         alive;
`ifdef UART_TX_PARITY_EN
    logic       pb;
`endif
    forever begin
      @(negedge clk);
      if (reset && tx == 1'b0) begin
        start_q.push_back(cyc);
        mon_wait(CPB / 2, alive);
        if (alive) check("mon_start_bit", int'(tx), 0);
        for (int i = 0; i < 8; i++) begin
          if (alive) begin
            mon_wait(CPB, alive);
            d[i] = tx;
          end
        end
`ifdef UART_TX_PARITY_EN
        pb = 1'b0;
        if (alive) begin
          mon_wait(CPB, alive);
          pb = tx;
        end
`endif
        if (alive) mon_wait(CPB, alive);
        if (alive) begin
          check("mon_stop_bit", int'(tx), 1);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL mon_unexpected_frame: got byte 0x%02h expected no frame", d);
          end else begin
            e = exp_q.pop_front();
            check("mon_byte", int'(d), int'(e));
`ifdef UART_TX_PARITY_EN
            check("mon_parity", int'(pb), int'(^e));
`endif
          end
        end
      end
    end
  end

  task automatic push(input logic [7:0] d, input bit acc);
    tx_data  = d;
    tx_valid = 1'b1;
    if (acc) exp_q.push_back(d);
    @(negedge clk);
  endtask

  task automatic wait_until_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (tx_busy && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("wait_idle_busy", int'(tx_busy), 0);
    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic send_single(input logic [7:0] d);
    logic [FB-1:0] fr;
    int            n;
`ifdef UART_TX_PARITY_EN
    fr = {1'b1, ^d, d, 1'b0};
`else
    fr = {1'b1, d, 1'b0};
`endif
    push(d, 1'b1);
    tx_valid = 1'b0;
    n = cyc;
    check("single_count_after_push", int'(tx_count), 1);
    check("single_tx_before_pop", int'(tx), 1);
    check("single_busy_after_push", int'(tx_busy), 1);
    for (int k = 0; k < FB * CPB; k++) begin
      @(negedge clk);
      if (k == 0) check("single_count_after_pop", int'(tx_count), 0);
      check($sformatf("single_tx_cycle%0d", k), int'(tx), int'(fr[k / CPB]));
    end
    check("single_busy_last_stop", int'(tx_busy), 1);
    @(negedge clk);
    check("single_busy_done", int'(tx_busy), 0);
    check("single_elapsed", cyc - n, FB * CPB + 1);
    wait_idle();
  endtask

  initial begin : stim
    int n;
    int i;
    int guard;
    int lows;

    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", int'(tx), 1);
    check("rst_ready", int'(tx_ready), 1);
    check("rst_busy", int'(tx_busy), 0);
    check("rst_count", int'(tx_count), 0);
    reset = 1'b1;
    @(negedge clk);

    send_single(8'h55);

    start_q.delete();
    push(8'hA3, 1'b1);
    push(8'h0F, 1'b1);
    tx_valid = 1'b0;
    wait_idle();
    check("b2b_frames", start_q.size(), 2);
    check("b2b_gap", (start_q.size() >= 2) ? (start_q[1] - start_q[0]) : -1, FB * CPB);

    push(8'h31, 1'b1);
    n = cyc;
    push(8'h32, 1'b1);
    check("full_first_popped", int'(tx_count), 1);
    push(8'h33, 1'b1);
    push(8'h34, 1'b1);
    push(8'h35, 1'b1);
    check("full_count", int'(tx_count), 4);
    check("full_ready_low", int'(tx_ready), 0);
    push(8'h36, 1'b0);
    tx_valid = 1'b0;
    check("full_refused_count", int'(tx_count), 4);
    wait_until_cyc(n + FB * CPB);
    check("full_ready_before_pop", int'(tx_ready), 0);
    check("full_count_before_pop", int'(tx_count), 4);
    @(negedge clk);
    check("full_ready_after_pop", int'(tx_ready), 1);
    check("full_count_after_pop", int'(tx_count), 3);
    wait_idle();

    i = 0;
    guard = 0;
    while (i < 12 && guard < 2000) begin
      if (tx_ready) begin
        tx_data  = 8'(i);
        tx_valid = 1'b1;
        exp_q.push_back(8'(i));
        i++;
      end else begin
        tx_valid = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    tx_valid = 1'b0;
    check("wrap_all_pushed", i, 12);
    wait_idle();

    push(8'hFF, 1'b1);
    n = cyc;
    push(8'h11, 1'b1);
    push(8'h22, 1'b1);
    tx_valid = 1'b0;
    wait_until_cyc(n + 1 + 4 * CPB + 1);
    reset = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_tx", int'(tx), 1);
    check("midrst_count", int'(tx_count), 0);
    check("midrst_busy", int'(tx_busy), 0);
    check("midrst_ready", int'(tx_ready), 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx == 1'b0) lows++;
    end
    check("midrst_quiet_tx_lows", lows, 0);
    check("midrst_quiet_busy", int'(tx_busy), 0);
    check("midrst_quiet_count", int'(tx_count), 0);

`ifdef UART_TX_PARITY_EN
    send_single(8'h07);
    send_single(8'h03);
`endif

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
